// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   Reset/NMI/IRQ/BRK entry sequencer for the 65c02 core. Sources are
//   arbitrated at instruction boundaries and each accepted source walks a
//   SEQ_LEN-step entry sequence. The last two steps present the vector
//   address with VPB low.
//
//   Clocking : all state updates on negedge phi2; resb is an async active-low reset.
//   Inputs   : rdy (advance/freeze), irqb (level IRQ), nmib (falling-edge NMI),
//              i_flag (status I bit), instr_done / brk_start (decoder pulses)
//   Outputs  : seq_active, seq_step, seq_kind (00 IRQ, 01 NMI, 10 RESET, 11 BRK),
//              vector_addr, vpb, write_inhibit, b_push,
//              seq_done / set_i / clear_d (last step with rdy=1)
module interrupt_sequencer #(
  parameter int          RESET_HOLD = 2,
  parameter int          SEQ_LEN    = 7,
  parameter logic [15:0] VEC_BASE   = 16'hFFFA,
  parameter int          STEP_W     = $clog2(SEQ_LEN)
) (
  input  logic              phi2,
  input  logic              resb,
  input  logic              rdy,
  input  logic              irqb,
  input  logic              nmib,
  input  logic              i_flag,
  input  logic              instr_done,
  input  logic              brk_start,
  output logic              seq_active,
  output logic [STEP_W-1:0] seq_step,
  output logic [1:0]        seq_kind,
  output logic [15:0]       vector_addr,
  output logic              vpb,
  output logic              write_inhibit,
  output logic              b_push,
  output logic              seq_done,
  output logic              set_i,
  output logic              clear_d
);

  typedef enum logic [1:0] {RST_WAIT, IDLE, RUN} state_e;
  typedef enum logic [1:0] {
    K_IRQ = 2'b00, K_NMI = 2'b01, K_RESET = 2'b10, K_BRK = 2'b11
  } kind_e;

  localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_VEC  = STEP_W'(SEQ_LEN - 2);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              nmi_prev_q, nmi_pend_q, nmi_pend_d;
  logic              brk_q, brk_d;   // sequence was entered via BRK; survives an NMI hijack
  logic              nmi_edge, nmi_clr;

  // nmi_prev resets to 0, so nmib already low at reset release is not an edge.
  assign nmi_edge = nmi_prev_q & ~nmib;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    step_d  = step_q;
    hold_d  = hold_q;
    brk_d   = brk_q;
    nmi_clr = 1'b0;
    case (state_q)
      RST_WAIT: begin
        // counts regardless of rdy; boundary pulses and IRQ are ignored here
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          kind_d  = K_RESET;
          step_d  = '0;
          brk_d   = 1'b0;
        end
      end
      IDLE: begin
        if (rdy) begin
          if (instr_done && nmi_pend_q) begin
            state_d = RUN;
            kind_d  = K_NMI;
            step_d  = '0;
            brk_d   = 1'b0;
            nmi_clr = 1'b1;
          end else if (instr_done && !irqb && !i_flag) begin
            state_d = RUN;
            kind_d  = K_IRQ;
            step_d  = '0;
            brk_d   = 1'b0;
          end else if (brk_start) begin
            state_d = RUN;
            kind_d  = K_BRK;
            step_d  = '0;
            brk_d   = 1'b1;
          end
        end
      end
      RUN: begin
        // A pending NMI takes over an IRQ/BRK entry while the vector fetch
        // has not started yet; later it waits for the next boundary.
        if (nmi_pend_q && (kind_q == K_IRQ || kind_q == K_BRK) && step_q < STEP_VEC) begin
          kind_d  = K_NMI;
          nmi_clr = 1'b1;
        end
        if (rdy) begin
          if (step_q == STEP_LAST) begin
            state_d = IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = RST_WAIT;
    endcase
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
  end

  always_ff @(negedge phi2 or negedge resb) begin
    if (!resb) begin
      state_q    <= RST_WAIT;
      kind_q     <= K_RESET;
      step_q     <= '0;
      hold_q     <= '0;
      brk_q      <= 1'b0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      brk_q      <= brk_d;
      nmi_prev_q <= nmib;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  logic [15:0] vec_lo;
  logic        vec_step;

  always_comb begin
    case (kind_q)
      K_NMI:   vec_lo = VEC_BASE;
      K_RESET: vec_lo = VEC_BASE + 16'd2;
      default: vec_lo = VEC_BASE + 16'd4;
    endcase
  end

  assign seq_active    = (state_q == RUN);
  assign seq_step      = step_q;
  assign seq_kind      = kind_q;
  assign vec_step      = seq_active && (step_q == STEP_VEC || step_q == STEP_LAST);
  assign vector_addr   = !vec_step ? 16'h0000 :
                         (step_q == STEP_LAST) ? vec_lo + 16'd1 : vec_lo;
  assign vpb           = ~vec_step;
  assign write_inhibit = seq_active && (kind_q == K_RESET);
  assign b_push        = seq_active && brk_q;
  assign seq_done      = seq_active && (step_q == STEP_LAST) && rdy;
  assign set_i         = seq_done;
  assign clear_d       = seq_done;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: a directed vector table (reset entry, IRQ
// masking/entry), hand sequences for the multi-cycle corners, then random
// stimulus, all checked every cycle against a behavioural model.
module tb_interrupt_sequencer;

  localparam int RESET_HOLD = 2;
  localparam int L          = 7;
  localparam int M_WAIT = 0, M_IDLE = 1, M_RUN = 2;

  logic        phi2 = 1'b1;
  logic        resb = 1'b0, rdy = 1'b1, irqb = 1'b1, nmib = 1'b1, i_flag = 1'b1;
  logic        instr_done = 1'b0, brk_start = 1'b0;
  logic        seq_active, vpb, write_inhibit, b_push, seq_done, set_i, clear_d;
  logic [2:0]  seq_step;
  logic [1:0]  seq_kind;
  logic [15:0] vector_addr;

  interrupt_sequencer #(.RESET_HOLD(RESET_HOLD), .SEQ_LEN(L), .VEC_BASE(16'hFFFA)) dut (
    .phi2(phi2), .resb(resb), .rdy(rdy), .irqb(irqb), .nmib(nmib), .i_flag(i_flag),
    .instr_done(instr_done), .brk_start(brk_start),
    .seq_active(seq_active), .seq_step(seq_step), .seq_kind(seq_kind),
    .vector_addr(vector_addr), .vpb(vpb), .write_inhibit(write_inhibit),
    .b_push(b_push), .seq_done(seq_done), .set_i(set_i), .clear_d(clear_d)
  );

  always #5 phi2 = ~phi2;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_mode, m_step, m_kind, m_hold;
  logic m_pend, m_prev, m_brk;

  task automatic model_reset();
    m_mode = M_WAIT; m_step = 0; m_kind = 2; m_hold = 0;
    m_pend = 1'b0; m_prev = 1'b0; m_brk = 1'b0;
  endtask

  task automatic model_start(input int k);
    m_mode = M_RUN; m_kind = k; m_step = 0; m_brk = (k == 3);
  endtask

  task automatic model_tick();
    logic nedge;
    if (!resb) begin
      model_reset();
      return;
    end
    nedge  = (nmib == 1'b0) && (m_prev == 1'b1);
    m_prev = nmib;
    case (m_mode)
      M_WAIT: begin
        m_hold++;
        if (m_hold == RESET_HOLD) model_start(2);
      end
      M_IDLE: if (rdy) begin
        if (instr_done && m_pend) begin model_start(1); m_pend = 1'b0; end
        else if (instr_done && !irqb && !i_flag) model_start(0);
        else if (brk_start) model_start(3);
      end
      default: begin
        if (m_pend && (m_kind == 0 || m_kind == 3) && m_step < L - 2) begin
          m_kind = 1; m_pend = 1'b0;
        end
        if (rdy) begin
          if (m_step == L - 1) begin m_mode = M_IDLE; m_step = 0; end
          else m_step++;
        end
      end
    endcase
    if (nedge) m_pend = 1'b1;
  endtask

  function automatic logic [27:0] model_out(input logic rdy_now);
    logic        act, v_pb, done;
    logic [15:0] base, vec;
    logic [2:0]  st;
    logic [1:0]  kd;
    act  = (m_mode == M_RUN);
    base = 16'hFFFA + ((m_kind == 1) ? 16'd0 : (m_kind == 2) ? 16'd2 : 16'd4);
    vec  = 16'h0000;
    v_pb = 1'b1;
    if (act && m_step == L - 2) begin vec = base;         v_pb = 1'b0; end
    if (act && m_step == L - 1) begin vec = base + 16'd1; v_pb = 1'b0; end
    done = act && (m_step == L - 1) && rdy_now;
    st   = m_step[2:0];
    kd   = m_kind[1:0];
    return {act, st, kd, vec, v_pb, act && (m_kind == 2), act && m_brk, done, done, done};
  endfunction

  // ---------------- cycle driver ----------------
  logic s_resb = 1'b0, s_rdy = 1'b1, s_irqb = 1'b1, s_nmib = 1'b1, s_ifl = 1'b1;
  logic        smp_act, smp_wi, smp_bp, smp_done, smp_vpb;
  logic [2:0]  smp_step;
  logic [1:0]  smp_kind;
  logic [15:0] smp_vec;

  task automatic tick(input logic idn, input logic brk);
    logic [27:0] o;
    @(posedge phi2);
    resb = s_resb; rdy = s_rdy; irqb = s_irqb; nmib = s_nmib; i_flag = s_ifl;
    instr_done = idn; brk_start = brk;
    if (!resb) model_reset();
    #1;
    o = {seq_active, seq_step, seq_kind, vector_addr, vpb, write_inhibit, b_push,
         seq_done, set_i, clear_d};
    smp_act = seq_active; smp_step = seq_step; smp_kind = seq_kind; smp_vec = vector_addr;
    smp_vpb = vpb; smp_wi = write_inhibit; smp_bp = b_push; smp_done = seq_done;
    check("model", {4'h0, o}, {4'h0, model_out(rdy)});
    @(negedge phi2);
    model_tick();
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 40 && m_mode != M_IDLE; i++) tick(1'b0, 1'b0);
    check("idle_timeout", {31'd0, m_mode == M_IDLE}, 32'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        r, irq, ifl, idn;
    logic        act;
    int          step;
    logic [1:0]  kind;
    logic [15:0] vec;
    logic        done;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, irq, ifl, idn, act, input int st,
                     input logic [1:0] kd, input logic [15:0] v, input logic dn);
    vec_t e;
    e.r = r; e.irq = irq; e.ifl = ifl; e.idn = idn;
    e.act = act; e.step = st; e.kind = kd; e.vec = v; e.done = dn;
    tbl.push_back(e);
  endtask

  initial begin
    int          cnt, stall;
    logic [1:0]  k;
    logic        bp, saw;
    logic [15:0] v;
    logic [2:0]  exp_st;

    model_reset();

    // reset held 3 cycles, release, RESET entry after RESET_HOLD cycles
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 2'b10, 16'h0, 0);
    for (int i = 0; i < 2; i++) add(1, 1, 1, 0, 0, 0, 2'b10, 16'h0, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 1, 0, 1, i, 2'b10, 16'h0, 0);
    add(1, 1, 1, 0, 1, 5, 2'b10, 16'hFFFC, 0);
    add(1, 1, 1, 0, 1, 6, 2'b10, 16'hFFFD, 1);
    add(1, 1, 1, 0, 0, 0, 2'b10, 16'h0, 0);
    // masked IRQ ignored, then unmasked IRQ accepted
    add(1, 0, 1, 1, 0, 0, 2'b10, 16'h0, 0);
    add(1, 0, 0, 1, 0, 0, 2'b10, 16'h0, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 1, i, 2'b00, 16'h0, 0);
    add(1, 1, 0, 0, 1, 5, 2'b00, 16'hFFFE, 0);
    add(1, 1, 0, 0, 1, 6, 2'b00, 16'hFFFF, 1);
    add(1, 1, 0, 0, 0, 0, 2'b00, 16'h0, 0);

    foreach (tbl[i]) begin
      s_resb = tbl[i].r; s_irqb = tbl[i].irq; s_ifl = tbl[i].ifl;
      tick(tbl[i].idn, 1'b0);
      exp_st = tbl[i].step[2:0];
      check("table", {9'd0, smp_act, smp_step, smp_kind, smp_vec, smp_done},
                     {9'd0, tbl[i].act, exp_st, tbl[i].kind, tbl[i].vec, tbl[i].done});
    end
    s_ifl = 1'b1; s_irqb = 1'b1;

    // NMI held low 20 cycles with two boundaries -> one NMI sequence
    tick(1'b0, 1'b0);
    s_nmib = 1'b0; cnt = 0; v = 16'h0;
    for (int i = 0; i < 20; i++) begin
      tick(i == 2 || i == 12, 1'b0);
      if (smp_act && smp_step == 3'd0 && smp_kind == 2'b01) cnt++;
      if (smp_act && smp_step == 3'(L - 2)) v = smp_vec;
    end
    check("nmi_once", cnt, 32'd1);
    check("nmi_vec", {16'd0, v}, 32'h0000FFFA);
    s_nmib = 1'b1;
    tick(1'b0, 1'b0);

    // NMI pending and IRQ asserted at the same boundary -> NMI
    s_nmib = 1'b0; tick(1'b0, 1'b0);
    s_nmib = 1'b1; tick(1'b0, 1'b0);
    s_irqb = 1'b0; s_ifl = 1'b0; tick(1'b1, 1'b0);
    s_irqb = 1'b1; s_ifl = 1'b1; tick(1'b0, 1'b0);
    check("nmi_wins", {29'd0, smp_act, smp_kind}, {29'd0, 1'b1, 2'b01});
    run_to_idle();

    // BRK hijacked by NMI edge at step 2
    tick(1'b0, 1'b1);
    k = 2'b00; bp = 1'b0; v = 16'h0;
    for (int i = 0; i < 20 && m_mode == M_RUN; i++) begin
      if (m_step == 2) s_nmib = 1'b0;
      tick(1'b0, 1'b0);
      if (smp_act && smp_step == 3'(L - 2)) begin k = smp_kind; bp = smp_bp; v = smp_vec; end
    end
    check("hijack_early", {13'd0, k, bp, v}, {13'd0, 2'b01, 1'b1, 16'hFFFA});
    s_nmib = 1'b1;
    run_to_idle();

    // NMI edge at step SEQ_LEN-2: BRK completes, NMI at the next boundary
    tick(1'b0, 1'b1);
    k = 2'b00; v = 16'h0;
    for (int i = 0; i < 20 && m_mode == M_RUN; i++) begin
      s_nmib = (m_step == L - 2) ? 1'b0 : 1'b1;
      tick(1'b0, 1'b0);
      if (smp_act && smp_step == 3'(L - 2)) begin k = smp_kind; v = smp_vec; end
    end
    check("hijack_late", {14'd0, k, v}, {14'd0, 2'b11, 16'hFFFE});
    s_nmib = 1'b1;
    run_to_idle();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("nmi_after_brk", {29'd0, smp_act, smp_kind}, {29'd0, 1'b1, 2'b01});
    run_to_idle();

    // rdy low 4 cycles at step 3 stretches the sequence to 11 cycles
    s_irqb = 1'b0; s_ifl = 1'b0; tick(1'b1, 1'b0);
    s_irqb = 1'b1; s_ifl = 1'b1;
    cnt = 0; stall = 0;
    for (int i = 0; i < 30 && m_mode == M_RUN; i++) begin
      s_rdy = !(m_step == 3 && stall < 4);
      if (!s_rdy) stall++;
      tick(1'b0, 1'b0);
      if (smp_act) cnt++;
    end
    s_rdy = 1'b1;
    check("rdy_stall_len", cnt, 32'd11);

    // reset in the middle of an IRQ sequence
    run_to_idle();
    s_irqb = 1'b0; s_ifl = 1'b0; tick(1'b1, 1'b0);
    s_irqb = 1'b1; s_ifl = 1'b1;
    for (int i = 0; i < 10 && m_step != 4; i++) tick(1'b0, 1'b0);
    s_resb = 1'b0; tick(1'b0, 1'b0);
    check("mid_reset", {28'd0, smp_act, smp_kind, smp_vpb}, {28'd0, 1'b0, 2'b10, 1'b1});
    tick(1'b0, 1'b0);
    s_resb = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      if (smp_act && smp_wi && smp_step == 3'(L - 1) && smp_vec == 16'hFFFD) saw = 1'b1;
    end
    check("reset_after_mid", {31'd0, saw}, 32'd1);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if (s_resb) s_resb = ($urandom_range(0, 299) != 0);
      else        s_resb = ($urandom_range(0, 1) != 0);
      s_rdy  = ($urandom_range(0, 3) != 0);
      s_irqb = ($urandom_range(0, 2) != 0);
      s_ifl  = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 7) == 0) s_nmib = ~s_nmib;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
